dac_sample_pacer: RTL and testbench



---
 rtl/dac_pacer_pkg.sv | 18 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/dac_sample_pacer.sv | 124 ++++++++++++
 tb/tb_dac_sample_pacer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pacer_pkg.sv
// Shared types and constants for the DAC sample pacer.
// Pure declarations: no latency and no backpressure of its own.
// Users import dac_pacer_pkg::* for the FSM type and the saturating increment.
package dac_pacer_pkg;

    localparam int CNT_WIDTH = 16;
    localparam int ACC_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } pacer_state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head read.
// Latency: a pushed word becomes visible at dout one cycle after the push.
// Backpressure: push is ignored when full and pop is ignored when empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra MSB on each pointer separates the full and empty cases.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces DDS samples to the DAC SPI controller at FS_HZ using a fractional tick; DAC_PACER_STATS_EN builds the counters.
// Latency: m_valid rises one cycle after a tick; a sample needs at least one cycle in the FIFO before it can be popped.
// Backpressure: s_ready = !full; a tick arriving while m_ready is still low is dropped and counted as late.
module dac_sample_pacer
    import dac_pacer_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int FS_HZ      = 1_041_100,
    parameter int F_CLK_SYS  = 100_000_000,
    parameter int MIDSCALE   = 2048
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         s_sample,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_WIDTH-1:0]         m_code,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          underrun_cnt,
    output logic [CNT_WIDTH-1:0]          late_cnt
);

    localparam logic [ACC_WIDTH-1:0] FS_STEP = ACC_WIDTH'(FS_HZ);
    localparam logic [ACC_WIDTH-1:0] FCLK    = ACC_WIDTH'(F_CLK_SYS);

    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic                  tick;
    pacer_state_t          state;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  push;
    logic                  pop;

    // acc < F_CLK_SYS and FS_HZ < F_CLK_SYS, so the sum never wraps 32 bits.
    assign acc_sum = acc + FS_STEP;
    assign tick    = (acc_sum >= FCLK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (tick) begin
            acc <= acc_sum - FCLK;
        end else begin
            acc <= acc_sum;
        end
    end

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;
    assign pop     = tick && (state == ST_IDLE) && !fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (s_sample),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            m_code <= DATA_WIDTH'(MIDSCALE);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_PRESENT;
                        // An empty FIFO re-presents the previous code.
                        if (!fifo_empty) begin
                            m_code <= fifo_head;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (m_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_valid = (state == ST_PRESENT);

`ifdef DAC_PACER_STATS_EN
    logic [CNT_WIDTH-1:0] underrun_q;
    logic [CNT_WIDTH-1:0] late_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= '0;
            late_q     <= '0;
        end else begin
            if (tick && (state == ST_IDLE) && fifo_empty) begin
                underrun_q <= sat_inc(underrun_q);
            end
            if (tick && (state == ST_PRESENT)) begin
                late_q <= sat_inc(late_q);
            end
        end
    end

    assign underrun_cnt = underrun_q;
    assign late_cnt     = late_q;
`else
    assign underrun_cnt = '0;
    assign late_cnt     = '0;
`endif

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer: a 4-cycle tick instance plus a default-rate instance.
// Counter expectations follow whether DAC_PACER_STATS_EN is defined for the build.
module tb_dac_sample_pacer;

`ifdef DAC_PACER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic [11:0] s_sample = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] m_code;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_cnt;
    logic [15:0] late_cnt;

    logic        s_ready2;
    logic [11:0] m_code2;
    logic        m_valid2;
    logic [3:0]  fifo_level2;
    logic [15:0] underrun_cnt2;
    logic [15:0] late_cnt2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en = 1'b0;
    logic [11:0] outq[$];

    always #5 clk = ~clk;

    dac_sample_pacer #(.FS_HZ(25_000_000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_sample     (s_sample),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_code       (m_code),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .late_cnt     (late_cnt)
    );

    dac_sample_pacer dut2 (
        .clk          (clk),
        .rst_n        (rst2_n),
        .s_sample     (12'd0),
        .s_valid      (1'b0),
        .s_ready      (s_ready2),
        .m_code       (m_code2),
        .m_valid      (m_valid2),
        .m_ready      (1'b1),
        .fifo_level   (fifo_level2),
        .underrun_cnt (underrun_cnt2),
        .late_cnt     (late_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (mon_en && m_valid && m_ready && outq.size() < 20) begin
            outq.push_back(m_code);
        end
    end

    int hs, bad, n, guard, maxl, cnt, first, prev, gmin, gmax;
    logic hs_now, saw_full;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_code", m_code, 2048);
        check("rst_valid", m_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_sready", s_ready, 1);
        check("rst_under", underrun_cnt, 0);
        check("rst_late", late_cnt, 0);

        // Prefill 1,2,3 then pace out one per 4 cycles, then underrun
        rst_n = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_sample = 12'd1;
        @(posedge clk); #1 s_sample = 12'd2;
        @(posedge clk); #1 s_sample = 12'd3;
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        check("pre_level", fifo_level, 3);
        @(posedge clk); @(negedge clk);
        check("t1_valid", m_valid, 1);
        check("t1_code", m_code, 1);
        @(posedge clk); @(negedge clk);
        check("t1_drop", m_valid, 0);
        repeat (3) @(posedge clk); @(negedge clk);
        check("t2_valid", m_valid, 1);
        check("t2_code", m_code, 2);
        repeat (4) @(posedge clk); @(negedge clk);
        check("t3_code", m_code, 3);
        repeat (4) @(posedge clk); @(negedge clk);
        check("t4_valid", m_valid, 1);
        check("t4_code", m_code, 3);
        check("t4_under", underrun_cnt, cnt_exp(1));

        // Continuous producer: FIFO fills, sequence is preserved
        s_valid = 1'b1; s_sample = 12'd100; n = 0; guard = 0; maxl = 0; saw_full = 1'b0;
        while (n < 20 && guard < 200) begin
            hs_now = s_ready;
            if (!s_ready) saw_full = 1'b1;
            if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
            @(posedge clk); #1;
            mon_en = 1'b1;
            guard++;
            if (hs_now) begin
                n++;
                s_sample = 12'(100 + n);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        guard = 0;
        while (outq.size() < 20 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        mon_en = 1'b0;
        check("fill_max", maxl, 8);
        check("fill_sready0", saw_full, 1);
        check("seq_len", outq.size(), 20);
        for (int i = 0; i < outq.size(); i++) begin
            check($sformatf("seq_%0d", i), outq[i], 100 + i);
        end

        // Fill to full while PRESENT, then reset mid-transfer
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; m_ready = 1'b0; s_valid = 1'b1; s_sample = 12'd300;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1 s_sample = 12'(300 + i);
        end
        s_valid = 1'b0;
        @(negedge clk);
        check("full_level", fifo_level, 8);
        check("full_sready", s_ready, 0);
        check("full_valid", m_valid, 1);
        check("full_code", m_code, 300);
        check("full_late", late_cnt, cnt_exp(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_code", m_code, 2048);
        check("arst_level", fifo_level, 0);
        check("arst_sready", s_ready, 1);
        check("arst_late", late_cnt, 0);
        check("arst_under", underrun_cnt, 0);

        // m_ready held low 10 cycles: stable code, late ticks, single transfer
        @(negedge clk);
        rst_n = 1'b1; s_valid = 1'b1; s_sample = 12'd200;
        @(posedge clk); #1 s_valid = 1'b0;
        repeat (3) @(posedge clk); @(negedge clk);
        check("hold_valid", m_valid, 1);
        check("hold_code", m_code, 200);
        bad = 0; hs = 0;
        for (int k = 5; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 14) m_ready = 1'b1;
            @(negedge clk);
            if (m_code !== 12'd200 || m_valid !== 1'b1) bad++;
            if (m_valid && m_ready) hs++;
        end
        check("hold_stable", bad, 0);
        check("hold_xfers", hs, 1);
        check("hold_late", late_cnt, cnt_exp(2));
        @(posedge clk); #1 s_valid = 1'b1; s_sample = 12'd201;
        @(negedge clk);
        check("rel_valid", m_valid, 0);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        check("nobypass_valid", m_valid, 1);
        check("nobypass_code", m_code, 200);
        check("nobypass_level", fifo_level, 1);
        check("nobypass_under", underrun_cnt, cnt_exp(1));
        repeat (4) @(posedge clk); @(negedge clk);
        check("next_code", m_code, 201);
        check("next_level", fifo_level, 0);
        check("next_late", late_cnt, cnt_exp(2));

        // Default rate: 104 ticks in 10000 cycles, first at 97, gaps 96/97
        @(negedge clk) rst2_n = 1'b1;
        cnt = 0; first = 0; prev = 0; gmin = 1000; gmax = 0;
        for (int i = 1; i <= 10000; i++) begin
            @(posedge clk); @(negedge clk);
            if (m_valid2) begin
                cnt++;
                if (cnt == 1) first = i;
                else begin
                    if (i - prev < gmin) gmin = i - prev;
                    if (i - prev > gmax) gmax = i - prev;
                end
                prev = i;
            end
        end
        check("rate_count", cnt, 104);
        check("rate_first", first, 97);
        check("rate_gmin", gmin, 96);
        check("rate_gmax", gmax, 97);
        check("rate_code", m_code2, 2048);
        check("rate_under", underrun_cnt2, cnt_exp(104));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
